// File: rtl/full_fn_acc_ppl_pkg.sv
// rtl/full_fn_acc_ppl_pkg.sv - shared op-bit indices, tag record and FSM encoding
package full_fn_acc_ppl_pkg;

   localparam int OP_RESTART = 0;
   localparam int OP_LAST    = 1;

   typedef struct packed {
      logic valid;
      logic restart;
      logic last;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/full_fn_acc_ppl_if.sv
// rtl/full_fn_acc_ppl_if.sv - custom-instruction handshake bundle between CPU and unit
interface full_fn_acc_ppl_if #(
   parameter int DATA_W = 32
);
   logic              clk_en;
   logic              start;
   logic [DATA_W-1:0] dataa;
   logic [31:0]       datab;
   logic [DATA_W-1:0] result;
   logic              done;

   modport master (output clk_en, start, dataa, datab, input result, done);
   modport slave  (input clk_en, start, dataa, datab, output result, done);
endinterface

// File: rtl/fn_cos_inner.sv
// rtl/fn_cos_inner.sv - stand-in for the pipelined cosine core: identity through LAT stages
module fn_cos_inner #(
   parameter int LAT = 15,
   parameter int W   = 32
) (
   input  logic         clock,
   input  logic         areset,
   input  logic         en,
   input  logic [W-1:0] a,
   output logic [W-1:0] q
);
   logic [W-1:0] pipe [LAT];

   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else if (en) begin
         pipe[0] <= a;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[LAT-1];
endmodule

// File: rtl/fp_acc.sv
// rtl/fp_acc.sv - stand-in for the fp32 accumulator core (truncating add, zero-flush)
module fp_acc #(
   parameter int LAT = 2
) (
   input  logic        clock,
   input  logic        areset,
   input  logic        en,
   input  logic        n,
   input  logic [31:0] x,
   output logic [31:0] r
);
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] hi, lo;
      logic [7:0]  e, sh;
      logic [24:0] mh, ml, m;
      if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
      else begin hi = b; lo = a; end
      e  = hi[30:23];
      sh = hi[30:23] - lo[30:23];
      mh = {1'b0, |hi[30:23], hi[22:0]};
      ml = (sh > 8'd24) ? 25'd0 : ({1'b0, |lo[30:23], lo[22:0]} >> sh);
      m  = (hi[31] == lo[31]) ? mh + ml : mh - ml;
      if (m[24]) begin m = m >> 1; e = e + 8'd1; end
      for (int i = 0; i < 24; i++)
         if (!m[23] && e > 8'd1) begin m = m << 1; e = e - 8'd1; end
      if (!m[23]) return 32'h0;
      return {hi[31], e, m[22:0]};
   endfunction

   logic [31:0] sum;

   always_ff @(posedge clock or posedge areset) begin
      if (areset)  sum <= '0;
      else if (en) sum <= n ? x : fadd(sum, x);
   end

   // Output stages free-run so the final sum settles even while en stays low
   generate
      if (LAT == 1) begin : g_direct
         assign r = sum;
      end else begin : g_dly
         logic [31:0] dly [LAT-1];
         always_ff @(posedge clock or posedge areset) begin
            if (areset) begin
               for (int i = 0; i < LAT-1; i++) dly[i] <= '0;
            end else begin
               dly[0] <= sum;
               for (int i = 1; i < LAT-1; i++) dly[i] <= dly[i-1];
            end
         end
         assign r = dly[LAT-2];
      end
   endgenerate
endmodule

// File: rtl/ppl_tag_delay.sv
// rtl/ppl_tag_delay.sv - enabled shift register with a mid tap and an end tap
module ppl_tag_delay #(
   parameter int DEPTH = 4,
   parameter int W     = 3,
   parameter int TAP   = 0
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q_tap,
   output logic [W-1:0] q_last
);
   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q_tap  = stage[TAP];
   assign q_last = stage[DEPTH-1];
endmodule

// File: rtl/full_fn_acc_ppl.sv
// rtl/full_fn_acc_ppl.sv - pipelined f(x) + fp accumulate unit with tag-aligned restart and done handshake
module full_fn_acc_ppl
   import full_fn_acc_ppl_pkg::*;
#(
   parameter int INNER_LAT = 15,
   parameter int ACC_LAT   = 2,
   parameter int DATA_W    = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   full_fn_acc_ppl_if.slave  bus
);
   localparam int L = INNER_LAT + ACC_LAT;

   state_t            state, state_next;
   tag_t              tag_in, tag_acc, tag_out;
   logic              areset, issue, exit_q;
   logic              done_q, done_next;
   logic [DATA_W-1:0] inner_q, acc_r, result_q, result_next;
   logic              unused_bits;

   assign areset      = ~reset_n;
   assign issue       = bus.start & (state == IDLE);
   assign tag_in      = tag_t'({issue, bus.datab[OP_RESTART], bus.datab[OP_LAST]});
   assign unused_bits = ^{bus.datab[31:2], tag_acc.last, tag_out.restart};

   ppl_tag_delay #(.DEPTH(L), .W(TAG_W), .TAP(INNER_LAT-1)) u_tags (
      .clock  (clock),
      .reset_n(reset_n),
      .en     (bus.clk_en),
      .d      (tag_in),
      .q_tap  (tag_acc),
      .q_last (tag_out)
   );

   fn_cos_inner #(.LAT(INNER_LAT), .W(DATA_W)) u_inner (
      .clock (clock),
      .areset(areset),
      .en    (bus.clk_en),
      .a     (bus.dataa),
      .q     (inner_q)
   );

   fp_acc #(.LAT(ACC_LAT)) u_acc (
      .clock (clock),
      .areset(areset),
      .en    (bus.clk_en & tag_acc.valid),
      .n     (tag_acc.restart),
      .x     (inner_q),
      .r     (acc_r)
   );

   // exit_q marks the cycle after the last-tagged token has left the final stage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         exit_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else if (bus.clk_en) begin
         state    <= state_next;
         exit_q   <= tag_out.valid & tag_out.last;
         done_q   <= done_next;
         result_q <= result_next;
      end
   end

   always_comb begin
      state_next  = state;
      done_next   = 1'b0;
      result_next = result_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.datab[OP_LAST]) state_next = WAIT;
               else                    done_next  = 1'b1;
            end
         end
         WAIT: begin
            if (exit_q) begin
               state_next  = IDLE;
               done_next   = 1'b1;
               result_next = acc_r;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.result = result_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_full_fn_acc_ppl.sv
// tb/tb_full_fn_acc_ppl.sv - directed plus random bench for full_fn_acc_ppl (two parameter builds)
module tb_full_fn_acc_ppl;
   localparam int IL_A  = 15;
   localparam int AL_A  = 2;
   localparam int IL_B  = 5;
   localparam int AL_B  = 3;
   localparam int LAT_A = IL_A + AL_A + 1;
   localparam int LAT_B = IL_B + AL_B + 1;

   logic        clock, reset_n, clk_en, start, sel;
   logic [31:0] dataa, datab;
   logic [31:0] res_o;
   logic        done_o;
   int          checks = 0;
   int          errors = 0;
   int          ref_sum [2];

   full_fn_acc_ppl_if #(.DATA_W(32)) bus_a ();
   full_fn_acc_ppl_if #(.DATA_W(32)) bus_b ();

   assign bus_a.clk_en = sel ? 1'b1 : clk_en;
   assign bus_a.start  = sel ? 1'b0 : start;
   assign bus_a.dataa  = dataa;
   assign bus_a.datab  = datab;
   assign bus_b.clk_en = sel ? clk_en : 1'b1;
   assign bus_b.start  = sel ? start : 1'b0;
   assign bus_b.dataa  = dataa;
   assign bus_b.datab  = datab;
   assign res_o  = sel ? bus_b.result : bus_a.result;
   assign done_o = sel ? bus_b.done : bus_a.done;

   full_fn_acc_ppl #(.INNER_LAT(IL_A), .ACC_LAT(AL_A), .DATA_W(32)) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(bus_a));
   full_fn_acc_ppl #(.INNER_LAT(IL_B), .ACC_LAT(AL_B), .DATA_W(32)) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(bus_b));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] f32(input int v);
      int a, m;
      logic [31:0] frac;
      if (v == 0) return 32'h0;
      a    = (v < 0) ? -v : v;
      m    = $clog2(a + 1) - 1;
      frac = (a << (23 - m)) & 32'h007F_FFFF;
      return {(v < 0), 8'(127 + m), frac[22:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_last(input int exp_wall, input int stall_at, input int stall_len,
                            input int poke_at, input logic [31:0] exp_res);
      int k;
      k = 0;
      check("no_done_at_last_issue", {31'd0, done_o}, 32'd0);
      while (!done_o && k < 80) begin
         clk_en = !((k + 1 >= stall_at) && (k + 1 < stall_at + stall_len));
         start  = (k + 1 == poke_at);
         datab  = 32'd0;
         dataa  = f32(100);
         step();
         k++;
      end
      clk_en = 1'b1;
      start  = 1'b0;
      check("last_latency", k, exp_wall);
      check("last_result", res_o, exp_res);
      step();
      check("done_single_cycle", {31'd0, done_o}, 32'd0);
   endtask

   task automatic do_op(input bit rs, input bit ls, input int v,
                        input int stall_at, input int stall_len, input int poke_at);
      logic [31:0] prev;
      prev  = res_o;
      dataa = f32(v);
      datab = {30'd0, ls, rs};
      start = 1'b1;
      step();
      start = 1'b0;
      ref_sum[sel] = rs ? v : ref_sum[sel] + v;
      if (!ls) begin
         check("nonlast_done", {31'd0, done_o}, 32'd1);
         check("nonlast_result_held", res_o, prev);
      end else begin
         wait_last((sel ? LAT_B : LAT_A) + stall_len, stall_at, stall_len, poke_at,
                   f32(ref_sum[sel]));
      end
   endtask

   initial begin
      int n, gaps, pulses;
      sel = 1'b0; clk_en = 1'b1; start = 1'b0; dataa = '0; datab = '0; reset_n = 1'b0;
      ref_sum[0] = 0;
      ref_sum[1] = 0;
      repeat (3) step();
      check("rst_result_a", bus_a.result, 32'd0);
      check("rst_done_a", {31'd0, bus_a.done}, 32'd0);
      check("rst_result_b", bus_b.result, 32'd0);
      check("rst_done_b", {31'd0, bus_b.done}, 32'd0);
      reset_n = 1'b1;
      step();

      do_op(1, 0, 1, 0, 0, 0);
      do_op(0, 0, 2, 0, 0, 0);
      do_op(0, 1, 3, 0, 0, 0);
      check("stream_sum_6", res_o, 32'h40C0_0000);

      do_op(1, 1, 5, 0, 0, 0);
      check("restart_last_5", res_o, 32'h40A0_0000);

      do_op(1, 0, 1, 0, 0, 0);
      step();
      check("bubble_no_done", {31'd0, done_o}, 32'd0);
      do_op(0, 0, 2, 0, 0, 0);
      step();
      do_op(0, 1, 3, 0, 0, 0);
      check("bubble_sum_6", res_o, 32'h40C0_0000);

      do_op(1, 1, 7, 5, 4, 2);
      do_op(0, 1, 1, 0, 0, 0);

      dataa = f32(9); datab = 32'h3; start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      reset_n = 1'b0;
      #1;
      check("rst_mid_done", {31'd0, done_o}, 32'd0);
      check("rst_mid_result", res_o, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      ref_sum[0] = 0;
      ref_sum[1] = 0;
      pulses = 0;
      repeat (25) begin
         step();
         if (done_o) pulses++;
      end
      check("rst_no_stale_done", pulses, 0);
      do_op(1, 1, 2, 0, 0, 0);
      check("after_reset_2", res_o, 32'h4000_0000);

      for (int s = 0; s < 4; s++) begin
         n = int'($urandom_range(1, 4));
         for (int i = 0; i < n; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 30)) - 10, 0, 0, 0);
            gaps = int'($urandom_range(0, 2));
            repeat (gaps) begin
               step();
               check("rand_gap_no_done", {31'd0, done_o}, 32'd0);
            end
         end
         do_op(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 30)) - 10, 0, 0, 0);
      end

      sel = 1'b1;
      step();
      do_op(1, 1, 1, 0, 0, 0);
      check("short_build_1", res_o, 32'h3F80_0000);
      sel = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
